// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared word and data-cache state types
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [2:0] {
        IDLE,
        WB,
        FILL,
        FLUSH,
        HALTED
    } dcache_state_t;

endpackage

// File: rtl/dcache_array.sv
// rtl/dcache_array.sv - direct-mapped line storage, one read port and one write port
module dcache_array
    import cpu_types_pkg::*;
#(
    parameter int SETS  = 16,
    parameter int IDX_W = $clog2(SETS),
    parameter int TAG_W = 32 - IDX_W - 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic             rd_dirty,
    output logic [TAG_W-1:0] rd_tag,
    output word_t            rd_data,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_valid,
    input  logic             wr_dirty,
    input  logic [TAG_W-1:0] wr_tag,
    input  word_t            wr_data
);

    logic [SETS-1:0]  valid_q, valid_d;
    logic [SETS-1:0]  dirty_q, dirty_d;
    logic [TAG_W-1:0] tag_mem  [SETS];
    word_t            data_mem [SETS];

    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        if (wr_en) begin
            valid_d[wr_idx] = wr_valid;
            dirty_d[wr_idx] = wr_dirty;
        end
    end

    // Only the status bits are reset; tag/data are meaningless while invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_dirty = dirty_q[rd_idx];
    assign rd_tag   = tag_mem[rd_idx];
    assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/dcache_responder.sv
// rtl/dcache_responder.sv - direct-mapped write-back data cache with halt-time flush
module dcache_responder
    import cpu_types_pkg::*;
#(
    parameter int SETS  = 16,
    parameter int CPUID = 0
) (
    input  logic  CLK,
    input  logic  nRST,
    input  logic  dmemREN,
    input  logic  dmemWEN,
    input  word_t dmemaddr,
    input  word_t dmemstore,
    output word_t dmemload,
    output logic  dcacheHit,
    input  logic  dhalt,
    output logic  flushed,
    output logic  dREN,
    output logic  dWEN,
    output word_t daddr,
    output word_t dstore,
    input  word_t dload,
    input  logic  dwait
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 32 - IDX_W - 2;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SETS - 1);

    typedef struct packed {
        logic             valid;
        logic             dirty;
        logic [TAG_W-1:0] tag;
        word_t            data;
    } dcache_line_t;

    dcache_state_t    state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;

    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] rd_idx;
    dcache_line_t     rd_line;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    dcache_line_t     wr_line;
    logic             tag_hit;
    logic             advance;

    assign req_idx = dmemaddr[IDX_W+1:2];
    assign req_tag = dmemaddr[31:IDX_W+2];
    assign rd_idx  = (state_q == FLUSH) ? cnt_q : req_idx;
    assign tag_hit = rd_line.valid && (rd_line.tag == req_tag);
    assign flushed = (state_q == HALTED);

    logic unused_ok;
    assign unused_ok = &{1'b0, dmemaddr[1:0], CPUID[0]};

    dcache_array #(
        .SETS  (SETS),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_array (
        .clk      (CLK),
        .rst_n    (nRST),
        .rd_idx   (rd_idx),
        .rd_valid (rd_line.valid),
        .rd_dirty (rd_line.dirty),
        .rd_tag   (rd_line.tag),
        .rd_data  (rd_line.data),
        .wr_en    (wr_en),
        .wr_idx   (wr_idx),
        .wr_valid (wr_line.valid),
        .wr_dirty (wr_line.dirty),
        .wr_tag   (wr_line.tag),
        .wr_data  (wr_line.data)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dREN      = 1'b0;
        dWEN      = 1'b0;
        daddr     = '0;
        dstore    = '0;
        dcacheHit = 1'b0;
        dmemload  = '0;
        wr_en     = 1'b0;
        wr_idx    = rd_idx;
        wr_line   = rd_line;
        advance   = 1'b0;

        case (state_q)
            IDLE: begin
                if (dhalt) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end else if (dmemREN || dmemWEN) begin
                    if (tag_hit) begin
                        dcacheHit = 1'b1;
                        // A simultaneous read and write is treated as a read.
                        if (dmemREN) begin
                            dmemload = rd_line.data;
                        end else begin
                            wr_en         = 1'b1;
                            wr_line.dirty = 1'b1;
                            wr_line.data  = dmemstore;
                        end
                    end else begin
                        state_d = (rd_line.valid && rd_line.dirty) ? WB : FILL;
                    end
                end
            end
            WB: begin
                dWEN   = 1'b1;
                daddr  = {rd_line.tag, req_idx, 2'b00};
                dstore = rd_line.data;
                if (!dwait) begin
                    wr_en         = 1'b1;
                    wr_line.dirty = 1'b0;
                    state_d       = FILL;
                end
            end
            FILL: begin
                dREN  = 1'b1;
                daddr = {dmemaddr[31:2], 2'b00};
                if (!dwait) begin
                    wr_en         = 1'b1;
                    wr_line.valid = 1'b1;
                    wr_line.dirty = 1'b0;
                    wr_line.tag   = req_tag;
                    wr_line.data  = dload;
                    state_d       = IDLE;
                end
            end
            FLUSH: begin
                if (rd_line.valid && rd_line.dirty) begin
                    dWEN    = 1'b1;
                    daddr   = {rd_line.tag, cnt_q, 2'b00};
                    dstore  = rd_line.data;
                    advance = !dwait;
                    if (!dwait) begin
                        wr_en         = 1'b1;
                        wr_line.dirty = 1'b0;
                    end
                end else begin
                    advance = 1'b1;
                end
                if (advance) begin
                    if (cnt_q == LAST_IDX) begin
                        state_d = HALTED;
                    end else begin
                        cnt_d = cnt_q + IDX_W'(1);
                    end
                end
            end
            HALTED: begin
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_dcache_responder.sv
// tb/tb_dcache_responder.sv - directed self-checking bench for dcache_responder
module tb_dcache_responder;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        dmemREN, dmemWEN, dhalt, dwait;
    logic [31:0] dmemaddr, dmemstore, dload;
    logic [31:0] dmemload, daddr, dstore;
    logic        dcacheHit, flushed, dREN, dWEN;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] wb_addr [4];
    logic [31:0] wb_data [4];

    dcache_responder #(.SETS(16), .CPUID(0)) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .dmemREN   (dmemREN),
        .dmemWEN   (dmemWEN),
        .dmemaddr  (dmemaddr),
        .dmemstore (dmemstore),
        .dmemload  (dmemload),
        .dcacheHit (dcacheHit),
        .dhalt     (dhalt),
        .flushed   (flushed),
        .dREN      (dREN),
        .dWEN      (dWEN),
        .daddr     (daddr),
        .dstore    (dstore),
        .dload     (dload),
        .dwait     (dwait)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        dmemREN = 1'b0; dmemWEN = 1'b0; dhalt = 1'b0; dwait = 1'b0;
        dmemaddr = '0; dmemstore = '0; dload = '0;
        tick();
        tick();
        nRST = 1'b1;
    endtask

    task automatic do_req(input logic [31:0] a, input logic we, input logic [31:0] d);
        logic seen;
        seen      = 1'b0;
        dmemaddr  = a;
        dmemstore = d;
        dmemWEN   = we;
        dmemREN   = !we;
        for (int n = 0; n < 20 && !seen; n++) begin
            #1;
            if (dcacheHit) seen = 1'b1;
            tick();
        end
        dmemREN = 1'b0;
        dmemWEN = 1'b0;
        check("req_done", {31'd0, seen}, 32'd1);
    endtask

    task automatic run_flush(output int nwr, output int nren, output int nhit);
        nwr = 0; nren = 0; nhit = 0;
        for (int i = 0; i < 4; i++) begin
            wb_addr[i] = '0;
            wb_data[i] = '0;
        end
        for (int n = 0; n < 60 && !flushed; n++) begin
            #1;
            if (dWEN && !dwait) begin
                if (nwr < 4) begin
                    wb_addr[nwr] = daddr;
                    wb_data[nwr] = dstore;
                end
                nwr++;
            end
            if (dREN) nren++;
            if (dcacheHit) nhit++;
            tick();
        end
        check("flush_done", {31'd0, flushed}, 32'd1);
    endtask

    initial begin
        int nwr, nren, nhit;

        // Reset state
        nRST = 1'b0;
        dmemREN = 1'b0; dmemWEN = 1'b0; dhalt = 1'b0; dwait = 1'b0;
        dmemaddr = 32'h40; dmemstore = 32'h1; dload = 32'h1;
        #2;
        check("rst_dren", {31'd0, dREN}, 32'd0);
        check("rst_dwen", {31'd0, dWEN}, 32'd0);
        check("rst_hit", {31'd0, dcacheHit}, 32'd0);
        check("rst_daddr", daddr, 32'd0);
        check("rst_dstore", dstore, 32'd0);
        check("rst_load", dmemload, 32'd0);
        check("rst_flushed", {31'd0, flushed}, 32'd0);
        do_reset();

        // Cold read miss, fill, then hits
        dmemaddr = 32'h40; dmemREN = 1'b1; dload = 32'hDEADBEEF;
        #1;
        check("cold_miss_hit", {31'd0, dcacheHit}, 32'd0);
        check("cold_miss_dren", {31'd0, dREN}, 32'd0);
        tick();
        check("cold_fill_dren", {31'd0, dREN}, 32'd1);
        check("cold_fill_addr", daddr, 32'h40);
        tick();
        check("cold_hit", {31'd0, dcacheHit}, 32'd1);
        check("cold_load", dmemload, 32'hDEADBEEF);
        check("cold_hit_dren", {31'd0, dREN}, 32'd0);
        tick();
        check("rehit", {31'd0, dcacheHit}, 32'd1);
        check("rehit_dren", {31'd0, dREN}, 32'd0);

        // Write hit, then conflicting read forces writeback
        dmemREN = 1'b0; dmemWEN = 1'b1; dmemstore = 32'h12345678;
        #1;
        check("whit", {31'd0, dcacheHit}, 32'd1);
        check("whit_dwen", {31'd0, dWEN}, 32'd0);
        tick();
        dmemWEN = 1'b0; dmemREN = 1'b1; dmemaddr = 32'h80; dload = 32'hAAAA0080;
        #1;
        check("conf_miss", {31'd0, dcacheHit}, 32'd0);
        tick();
        check("wb_dwen", {31'd0, dWEN}, 32'd1);
        check("wb_addr", daddr, 32'h40);
        check("wb_data", dstore, 32'h12345678);
        tick();
        check("wb_fill_dren", {31'd0, dREN}, 32'd1);
        check("wb_fill_addr", daddr, 32'h80);
        tick();
        check("wb_hit", {31'd0, dcacheHit}, 32'd1);
        check("wb_load", dmemload, 32'hAAAA0080);
        dmemREN = 1'b0;
        tick();

        // Fill stalled by dwait for 5 cycles
        dmemaddr = 32'h104; dmemREN = 1'b1; dwait = 1'b1; dload = 32'h55AA0104;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("stall_dren", {31'd0, dREN}, 32'd1);
            check("stall_addr", daddr, 32'h104);
            check("stall_hit", {31'd0, dcacheHit}, 32'd0);
            tick();
        end
        dwait = 1'b0;
        #1;
        check("stall_last_dren", {31'd0, dREN}, 32'd1);
        tick();
        check("stall_hit_done", {31'd0, dcacheHit}, 32'd1);
        check("stall_load", dmemload, 32'h55AA0104);
        dmemREN = 1'b0;
        tick();

        // Reset in the middle of a writeback
        do_req(32'h208, 1'b1, 32'hBEEF0208);
        dmemaddr = 32'h248; dmemREN = 1'b1; dwait = 1'b1;
        #1;
        check("mwb_miss", {31'd0, dcacheHit}, 32'd0);
        tick();
        check("mwb_dwen", {31'd0, dWEN}, 32'd1);
        check("mwb_addr", daddr, 32'h208);
        check("mwb_data", dstore, 32'hBEEF0208);
        nRST = 1'b0;
        #1;
        check("mwb_rst_dwen", {31'd0, dWEN}, 32'd0);
        check("mwb_rst_dren", {31'd0, dREN}, 32'd0);
        tick();
        nRST = 1'b1; dmemREN = 1'b0; dwait = 1'b0;
        tick();
        dmemaddr = 32'h80; dmemREN = 1'b1;
        #1;
        check("post_rst_miss80", {31'd0, dcacheHit}, 32'd0);
        tick();
        check("post_rst_fill80", {31'd0, dREN}, 32'd1);
        check("post_rst_addr80", daddr, 32'h80);
        tick();
        dmemREN = 1'b0;
        tick();
        dmemaddr = 32'h104; dmemREN = 1'b1;
        #1;
        check("post_rst_miss104", {31'd0, dcacheHit}, 32'd0);
        dmemaddr = 32'h208;
        #1;
        check("post_rst_miss208", {31'd0, dcacheHit}, 32'd0);

        // Flush with dirty lines at indices 0, 3 and 15
        do_reset();
        tick();
        do_req(32'h0, 1'b1, 32'hA0);
        do_req(32'hC, 1'b1, 32'hA3);
        do_req(32'h3C, 1'b1, 32'hAF);
        do_req(32'h10, 1'b0, 32'h0);
        dhalt = 1'b1;
        run_flush(nwr, nren, nhit);
        check("fl_count", nwr, 32'd3);
        check("fl_addr0", wb_addr[0], 32'h0);
        check("fl_data0", wb_data[0], 32'hA0);
        check("fl_addr1", wb_addr[1], 32'hC);
        check("fl_data1", wb_data[1], 32'hA3);
        check("fl_addr2", wb_addr[2], 32'h3C);
        check("fl_data2", wb_data[2], 32'hAF);
        check("fl_dren", nren, 32'd0);
        check("fl_hit", nhit, 32'd0);
        dmemREN = 1'b1; dmemaddr = 32'h0;
        tick(); tick(); tick();
        check("halt_flushed", {31'd0, flushed}, 32'd1);
        check("halt_dwen", {31'd0, dWEN}, 32'd0);
        check("halt_dren", {31'd0, dREN}, 32'd0);
        check("halt_hit", {31'd0, dcacheHit}, 32'd0);

        // dhalt raised while a fill is outstanding
        do_reset();
        tick();
        dmemaddr = 32'h300; dmemREN = 1'b1; dwait = 1'b1; dload = 32'h77;
        tick();
        check("hf_dren", {31'd0, dREN}, 32'd1);
        check("hf_addr", daddr, 32'h300);
        dhalt = 1'b1;
        tick();
        check("hf_still_fill", {31'd0, dREN}, 32'd1);
        tick();
        dwait = 1'b0;
        run_flush(nwr, nren, nhit);
        check("hf_hit", nhit, 32'd0);
        check("hf_wr", nwr, 32'd0);
        check("hf_flushed", {31'd0, flushed}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
